ysyx_23060201_isram: RTL and testbench
======================================

// Module: ysyx_23060201_isram
// PURPOSE
// - Instruction-memory slave directly upstream of the fetch stage; serves one 32-bit instruction word per request.
// - Fetch side talks to it over an AXI4-Lite read channel (AR + R), replacing the combinational DPI fetch.
// - Storage is the simulator's physical memory, read through DPI-C pmem_read(addr, 8'b1111).
// - Latency is configurable so fetch/stall logic is exercised against non-zero memory delay.
// PARAMETERS
// - ADDR_WIDTH  32      address width, byte address
// - DATA_WIDTH  32      read data width; only 32 is supported
// - LATENCY     1       wait cycles between AR handshake and rvalid (0..2**CNT_WIDTH-1)
// - CNT_WIDTH   4       width of the latency down-counter
// PORTS
// - clk      in   1           clock; all state updates on posedge
// - rst      in   1           asynchronous reset, active-high
// - araddr   in   ADDR_WIDTH  read address from fetch
// - arvalid  in   1           read address valid
// - arready  out  1           slave can accept an address (registered)
// - rdata    out  DATA_WIDTH  instruction word
// - rresp    out  2           2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR
// - rvalid   out  1           read data valid (registered)
// - rready   in   1           fetch accepts read data
// BEHAVIOUR
// - Reset values: state IDLE, arready 0, rvalid 0, rdata 0, rresp 2'b00, counter 0, latched addr 0.
// - Reset is asynchronous; asserting it mid-transaction drops any in-flight request. No response is issued for it.
// - arready rises on the first posedge after rst deasserts.
// - FSM IDLE -> WAIT -> RESP -> IDLE. The slave holds one outstanding read at most.
// - IDLE:
//   - arready = 1.
//   - On arvalid & arready: latch araddr and set arready <= 0.
//   - If LATENCY==0, go to RESP. Otherwise load counter <= LATENCY-1 and go to WAIT.
// - WAIT:
//   - Decrement counter each cycle.
//   - When counter==0, go to RESP and capture the response in the same edge.
// - Timing: handshake in cycle T; rvalid first high in cycle T+1+LATENCY.
// - Response capture, in priority order:
//   - addr < `MBASE: rresp = DECERR, rdata = 0, no pmem_read.
//   - addr[1:0] != 0: rresp = SLVERR, rdata = 0, no pmem_read.
//   - Otherwise: rresp = OKAY, rdata = pmem_read(addr, 8'b1111).
// - RESP:
//   - rvalid = 1. rdata and rresp stay stable until rready.
//   - On rvalid & rready: rvalid <= 0, arready <= 1, go to IDLE.
//   - The next request can be accepted the cycle after R completes (no AR/R overlap).
// - arvalid is ignored in WAIT and RESP because arready = 0 there. The master must hold araddr stable while arvalid & !arready.
// - Back-pressure: rready low for any number of cycles must not corrupt rdata or rresp.
// - pmem_read is called exactly once per OKAY transaction.
// CONFIGURATION
// - Macro YSYX_23060201_ISRAM_RANDLAT_EN.
// - Defined:
//   - The WAIT length is taken from the low CNT_WIDTH bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset).
//   - The LFSR steps once per accepted request. LATENCY is ignored.
//   - A sampled value of 0 means direct IDLE -> RESP.
// - Undefined: fixed LATENCY, and no LFSR logic is present.
// STRUCTURE
// - defines.v (shared):
//   - `MBASE.
//   - AXI resp codes `AXI_RESP_OKAY 2'b00, `AXI_RESP_SLVERR 2'b10, `AXI_RESP_DECERR 2'b11.
//   - FSM state encodings `ISRAM_IDLE/`ISRAM_WAIT/`ISRAM_RESP (2 bits).
// - One sub-module, ysyx_23060201_LFSR (16-bit, enable, async active-high reset).
//   - Instantiated only under YSYX_23060201_ISRAM_RANDLAT_EN.
// - FSM, counter and response registers live in this module. The DPI import is declared here.
// TESTING
// 1. Reset: rst=1 for 3 cycles, then 0 -> arready=0, rvalid=0 during reset; arready=1 at first edge after release.
// 2. LATENCY=1, mem[0x8000_0000]=0x0010_0093, araddr=0x8000_0000, arvalid 1 cycle, rready=1 ->
//    rvalid high exactly at T+2, rdata=0x0010_0093, rresp=00, arready back to 1 the next cycle.
// 3. LATENCY=0, back-to-back fetches 0x8000_0000 then 0x8000_0004 -> each rvalid 1 cycle after its handshake;
//    second AR is accepted only after the first R completes.
// 4. Back-pressure: rready=0 for 5 cycles after rvalid -> rdata/rresp constant, arready=0, and a second arvalid is not accepted.
// 5. Errors: araddr=0x7FFF_FFFC -> rresp=11, rdata=0; araddr=0x8000_0002 -> rresp=10, rdata=0; no pmem_read call (DPI counter unchanged).
// 6. Reset mid-WAIT (LATENCY=5, rst pulsed at T+2) -> rvalid never asserts for the dropped request; a fresh fetch afterwards returns correct data.

Source files
------------

// File: rtl/ysyx_23060201_isram_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : ysyx_23060201_isram_pkg                                        |
// | Brief    : Shared defines, FSM state type, AXI response codes and the     |
// |            in-simulator instruction memory model behind pmem_read.        |
// |            YSYX_23060201_ISRAM_DPI selects the external DPI-C memory      |
// |            instead of the built-in model.                                |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef MBASE
`define MBASE 32'h8000_0000
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif
`ifndef ISRAM_IDLE
`define ISRAM_IDLE 2'd0
`define ISRAM_WAIT 2'd1
`define ISRAM_RESP 2'd2
`endif

package ysyx_23060201_isram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `ISRAM_IDLE,
    ST_WAIT = `ISRAM_WAIT,
    ST_RESP = `ISRAM_RESP
  } isram_state_t;

  localparam logic [1:0] C_RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [1:0] C_RESP_SLVERR = `AXI_RESP_SLVERR;
  localparam logic [1:0] C_RESP_DECERR = `AXI_RESP_DECERR;

`ifndef YSYX_23060201_ISRAM_DPI
  // Word-addressed backing store starting at MBASE (256 words, wraps).
  logic [31:0] pmem_words [0:255];
  // Number of memory reads performed, visible to whoever loads the memory.
  int unsigned pmem_read_calls;

  function automatic void pmem_load(input logic [7:0] idx, input logic [31:0] data);
    pmem_words[idx] = data;
  endfunction

  function automatic logic [31:0] pmem_read(input logic [31:0] raddr, input logic [7:0] rmask);
    logic [31:0] offset;
    logic        unused_bits;
    offset          = raddr - `MBASE;
    unused_bits     = ^{offset[31:10], offset[1:0], rmask};
    pmem_read_calls = pmem_read_calls + 1;
    return pmem_words[offset[9:2]];
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/ysyx_23060201_isram_lfsr.sv
// +--------------------------------------------------------------------------+
// | Module   : ysyx_23060201_LFSR                                             |
// | Brief    : 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable,     |
// |            used for random fetch latency. Present only when               |
// |            YSYX_23060201_ISRAM_RANDLAT_EN is defined.                     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifdef YSYX_23060201_ISRAM_RANDLAT_EN
module ysyx_23060201_LFSR #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic w_fb;

  assign w_fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  // Shift one step per enabled cycle; seed restored on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], w_fb};
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/ysyx_23060201_isram.sv
// +--------------------------------------------------------------------------+
// | Module   : ysyx_23060201_isram                                            |
// | Brief    : AXI4-Lite read-only instruction memory slave (AR + R) with     |
// |            configurable response latency. One outstanding read.           |
// |            YSYX_23060201_ISRAM_RANDLAT_EN: LFSR-driven random latency.    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_23060201_isram
  import ysyx_23060201_isram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  isram_state_t          r_state;
  isram_state_t          w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_lat;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_cap_addr;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_capture;
  logic                  w_decerr;
  logic                  w_slverr;

  assign w_ar_hs = arvalid & arready;
  assign w_r_hs  = rvalid & rready;

`ifdef YSYX_23060201_ISRAM_RANDLAT_EN
  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;

  // Latency is sampled before the LFSR steps for this request.
  ysyx_23060201_LFSR u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_ar_hs),
    .q   (w_lfsr)
  );

  assign w_lat         = w_lfsr[CNT_WIDTH-1:0];
  assign w_lfsr_unused = ^w_lfsr[15:CNT_WIDTH];
`else
  assign w_lat = CNT_WIDTH'(LATENCY);
`endif

  // Response is captured on the edge that enters RESP. With zero latency that
  // is the handshake edge itself, so the live address is used from IDLE.
  assign w_capture  = (r_state != ST_RESP) && (w_next == ST_RESP);
  assign w_cap_addr = (r_state == ST_IDLE) ? araddr : r_addr;
  assign w_decerr   = w_cap_addr < ADDR_WIDTH'(`MBASE);
  assign w_slverr   = w_cap_addr[1:0] != 2'b00;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_ar_hs) w_next = (w_lat == '0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (w_r_hs) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake flags track the state being entered so both are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      arready <= (w_next == ST_IDLE);
      rvalid  <= (w_next == ST_RESP);
    end
  end

  // Latch request address and run the wait down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_addr <= araddr;
      end
      if ((r_state == ST_IDLE) && w_ar_hs && (w_lat != '0)) begin
        r_cnt <= w_lat - 1'b1;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Capture the response once per request; memory is read only for OKAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      rresp <= C_RESP_OKAY;
    end else if (w_capture) begin
      if (w_decerr) begin
        rresp <= C_RESP_DECERR;
        rdata <= '0;
      end else if (w_slverr) begin
        rresp <= C_RESP_SLVERR;
        rdata <= '0;
      end else begin
        rresp <= C_RESP_OKAY;
        rdata <= DATA_WIDTH'(pmem_read(32'(w_cap_addr), 8'b1111));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060201_isram.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_ysyx_23060201_isram                                         |
// | Brief    : Directed self-checking bench; three instances with LATENCY     |
// |            0, 1 and 5 share clock and reset.                              |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_23060201_isram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr  [3];
  logic        arvalid [3];
  logic        arready [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic        rvalid  [3];
  logic        rready  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Index 0: LATENCY=0, index 1: LATENCY=1, index 2: LATENCY=5.
  ysyx_23060201_isram #(.LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]));
  ysyx_23060201_isram #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]));
  ysyx_23060201_isram #(.LATENCY(5)) u_dut_l5 (
    .clk(clk), .rst(rst), .araddr(araddr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
    .rdata(rdata[2]), .rresp(rresp[2]), .rvalid(rvalid[2]), .rready(rready[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete read with rready held high; checks latency, payload, release.
  task automatic do_read(input int k, input logic [31:0] addr, input int lat,
                         input logic [1:0] resp, input logic [31:0] data, input string tag);
    int          n;
    int unsigned calls0;
    calls0 = ysyx_23060201_isram_pkg::pmem_read_calls;
    check_val({tag, ".arready_pre"}, 32'(arready[k]), 32'd1);
    araddr[k]  = addr;
    arvalid[k] = 1'b1;
    tick();
    arvalid[k] = 1'b0;
    n = 0;
    while (rvalid[k] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, ".latency"}, 32'(n), 32'(lat));
    check_val({tag, ".rdata"}, rdata[k], data);
    check_val({tag, ".rresp"}, 32'(rresp[k]), 32'(resp));
    tick();
    check_val({tag, ".rvalid_done"}, 32'(rvalid[k]), 32'd0);
    check_val({tag, ".arready_back"}, 32'(arready[k]), 32'd1);
    check_val({tag, ".pmem_calls"}, ysyx_23060201_isram_pkg::pmem_read_calls - calls0,
              (resp == 2'b00) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int          seen;
    int unsigned calls0;
    for (int k = 0; k < 3; k++) begin
      araddr[k]  = '0;
      arvalid[k] = 1'b0;
      rready[k]  = 1'b1;
    end
    ysyx_23060201_isram_pkg::pmem_load(8'd0, 32'h0010_0093);
    ysyx_23060201_isram_pkg::pmem_load(8'd1, 32'h0040_0113);
    ysyx_23060201_isram_pkg::pmem_load(8'd2, 32'hDEAD_BEEF);

    // 1: reset behaviour
    tick();
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t1.rst_arready%0d", k), 32'(arready[k]), 32'd0);
      check_val($sformatf("t1.rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
      check_val($sformatf("t1.rst_rdata%0d", k), rdata[k], 32'd0);
      check_val($sformatf("t1.rst_rresp%0d", k), 32'(rresp[k]), 32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    check_val("t1.arready_before_edge", 32'(arready[1]), 32'd0);
    tick();
    for (int k = 0; k < 3; k++)
      check_val($sformatf("t1.arready_up%0d", k), 32'(arready[k]), 32'd1);

    // 2: single fetch, LATENCY=1
    do_read(1, 32'h8000_0000, 1, 2'b00, 32'h0010_0093, "t2");

    // 3: back-to-back fetches, LATENCY=0
    araddr[0]  = 32'h8000_0000;
    arvalid[0] = 1'b1;
    tick();
    check_val("t3.first_rvalid", 32'(rvalid[0]), 32'd1);
    check_val("t3.first_rdata", rdata[0], 32'h0010_0093);
    check_val("t3.first_arready", 32'(arready[0]), 32'd0);
    araddr[0] = 32'h8000_0004;
    tick();
    check_val("t3.gap_rvalid", 32'(rvalid[0]), 32'd0);
    check_val("t3.gap_arready", 32'(arready[0]), 32'd1);
    tick();
    arvalid[0] = 1'b0;
    check_val("t3.second_rvalid", 32'(rvalid[0]), 32'd1);
    check_val("t3.second_rdata", rdata[0], 32'h0040_0113);
    check_val("t3.second_rresp", 32'(rresp[0]), 32'd0);
    tick();
    check_val("t3.second_done", 32'(rvalid[0]), 32'd0);

    // 4: back-pressure, LATENCY=1, with a competing arvalid
    calls0     = ysyx_23060201_isram_pkg::pmem_read_calls;
    rready[1]  = 1'b0;
    araddr[1]  = 32'h8000_0008;
    arvalid[1] = 1'b1;
    tick();
    arvalid[1] = 1'b0;
    tick();
    araddr[1]  = 32'h8000_0004;
    arvalid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t4.rvalid_c%0d", i), 32'(rvalid[1]), 32'd1);
      check_val($sformatf("t4.rdata_c%0d", i), rdata[1], 32'hDEAD_BEEF);
      check_val($sformatf("t4.rresp_c%0d", i), 32'(rresp[1]), 32'd0);
      check_val($sformatf("t4.arready_c%0d", i), 32'(arready[1]), 32'd0);
      tick();
    end
    arvalid[1] = 1'b0;
    rready[1]  = 1'b1;
    tick();
    check_val("t4.released", 32'(rvalid[1]), 32'd0);
    check_val("t4.arready_back", 32'(arready[1]), 32'd1);
    tick();
    tick();
    check_val("t4.no_phantom", 32'(rvalid[1]), 32'd0);
    check_val("t4.pmem_calls", ysyx_23060201_isram_pkg::pmem_read_calls - calls0, 32'd1);

    // 5: error responses, no memory access
    do_read(1, 32'h7FFF_FFFC, 1, 2'b11, 32'h0, "t5.decerr");
    do_read(1, 32'h8000_0002, 1, 2'b10, 32'h0, "t5.slverr");

    // 6: reset mid-WAIT on the LATENCY=5 instance
    araddr[2]  = 32'h8000_0000;
    arvalid[2] = 1'b1;
    tick();
    arvalid[2] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("t6.async_arready_idle", 32'(arready[0]), 32'd0);
    check_val("t6.async_rvalid", 32'(rvalid[2]), 32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid[2] === 1'b1) seen++;
    end
    check_val("t6.dropped_no_rvalid", 32'(seen), 32'd0);
    do_read(2, 32'h8000_0004, 5, 2'b00, 32'h0040_0113, "t6.fresh");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
